// File: rtl/clk_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_meter_pkg
// Shared definitions for the clock/pulse-train meter:
//   - default counter width and stop-detection timeout (also used by the
//     board-level divider instantiations so both ends agree)
//   - FSM state encoding
// -----------------------------------------------------------------------------
package clk_meter_pkg;

    localparam int unsigned CLK_METER_WIDTH   = 32;
    localparam int unsigned CLK_METER_TIMEOUT = 200_000_000;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous level into the clk domain through a 2-FF
// synchronizer, then compares it with a one-cycle delayed copy to produce
// single-cycle rise/fall strobes. Reusable for button inputs.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (all stages to 0)
//   srst   - synchronous soft reset (all stages to 0)
//   sig_in - asynchronous input level
//   rise   - high for one cycle after the synchronized level goes 0->1
//   fall   - high for one cycle after the synchronized level goes 1->0
// -----------------------------------------------------------------------------
module sync_edge
    import clk_meter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic dly_r;

    // Synchronizer chain followed by the edge-detect delay stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            dly_r  <= 1'b0;
        end else if (srst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            dly_r  <= 1'b0;
        end else begin
            meta_r <= sig_in;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign rise = sync_r & ~dly_r;
    assign fall = ~sync_r & dly_r;

endmodule

// File: rtl/clk_meter.sv
// -----------------------------------------------------------------------------
// clk_meter
// Measures period and high time of a slow external square wave in clk cycles.
// The first rising edge after reset/enable/timeout only arms the counter;
// every later rising edge publishes the cycle just completed.
// Parameters:
//   WIDTH   - counter and result width
//   TIMEOUT - cycles without a rising edge before the input counts as stopped
//             (2 <= TIMEOUT < 2**WIDTH, so the counter never wraps)
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   en         - synchronous measurement enable
//   sig_in     - asynchronous signal under measurement
//   period     - cycles between the last two rising edges
//   high_time  - cycles the signal was high within that period
//   valid      - one-cycle strobe when period/high_time update
//   timeout    - sticky stop flag, cleared by the next valid
// -----------------------------------------------------------------------------
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned WIDTH   = CLK_METER_WIDTH,
    parameter int unsigned TIMEOUT = CLK_METER_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

    logic             rise_s;
    logic             fall_s;
    meter_state_e     state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] hi_lat_r;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] high_time_r;
    logic             valid_r;
    logic             timeout_r;

    // The synchronizer keeps running regardless of en; no soft reset needed here
    sync_edge u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .srst   (1'b0),
        .sig_in (sig_in),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // Measurement FSM, cycle counter, high-time latch and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= ZERO_C;
            hi_lat_r    <= ZERO_C;
            period_r    <= ZERO_C;
            high_time_r <= ZERO_C;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (!en) begin
                // Disabling discards the partial period but keeps published results
                state_r  <= IDLE;
                cnt_r    <= ZERO_C;
                hi_lat_r <= ZERO_C;
            end else begin
                case (state_r)
                    IDLE: begin
                        cnt_r <= ZERO_C;
                        if (rise_s) begin
                            // Arming edge: start counting, publish nothing yet
                            cnt_r   <= ONE_C;
                            state_r <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        cnt_r <= cnt_r + ONE_C;
                        if (fall_s) begin
                            hi_lat_r <= cnt_r;
                        end
                        // A rise landing on the timeout cycle is a legal period
                        if (rise_s) begin
                            period_r    <= cnt_r;
                            high_time_r <= hi_lat_r;
                            valid_r     <= 1'b1;
                            timeout_r   <= 1'b0;
                            cnt_r       <= ONE_C;
                        end else if (cnt_r == TIMEOUT_C) begin
                            period_r    <= ZERO_C;
                            high_time_r <= ZERO_C;
                            timeout_r   <= 1'b1;
                            cnt_r       <= ZERO_C;
                            state_r     <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO_C;
                    end
                endcase
            end
        end
    end

    assign period    = period_r;
    assign high_time = high_time_r;
    assign valid     = valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_clk_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_meter
// Drives square waves (directed and randomized) into clk_meter and compares
// all outputs every cycle with an event-time reference model: it records the
// clock index at which each edge becomes visible to the meter and derives
// period/high_time/timeout from differences of those indices.
// -----------------------------------------------------------------------------
module tb_clk_meter;

    localparam int W  = 32;
    localparam int TO = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;

    clk_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int       cyc;
    bit       armed;
    int       last_rise;
    int       last_fall;
    bit       hist [4];
    bit [31:0] m_period;
    bit [31:0] m_high;
    bit        m_valid;
    bit        m_timeout;

    // Waveform generator state
    int hi_len = 10;
    int lo_len = 10;
    int phase  = 0;
    int en_off = 0;
    bit rand_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        armed     = 1'b0;
        last_rise = 0;
        last_fall = 0;
        for (int i = 0; i < 4; i++) hist[i] = 1'b0;
        m_period  = '0;
        m_high    = '0;
        m_valid   = 1'b0;
        m_timeout = 1'b0;
    endtask

    // Called just after each rising clk edge, with the inputs the DUT sampled
    task automatic model_edge();
        bit r;
        bit f;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = sig_in;
        // An input change is seen by the meter two samples later
        r = hist[2] & ~hist[3];
        f = ~hist[2] & hist[3];
        m_valid = 1'b0;
        if (!en) begin
            armed = 1'b0;
        end else if (!armed) begin
            if (r) begin
                armed     = 1'b1;
                last_rise = cyc;
            end
        end else begin
            if (f) last_fall = cyc;
            if (r) begin
                m_period  = 32'(cyc - last_rise);
                m_high    = 32'(last_fall - last_rise);
                m_valid   = 1'b1;
                m_timeout = 1'b0;
                last_rise = cyc;
            end else if (cyc - last_rise == TO) begin
                m_period  = '0;
                m_high    = '0;
                m_timeout = 1'b1;
                armed     = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "valid"},     32'(valid),   32'(m_valid));
        chk({pfx, "period"},    period,       m_period);
        chk({pfx, "high_time"}, high_time,    m_high);
        chk({pfx, "timeout"},   32'(timeout), 32'(m_timeout));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("");
        sig_in = (phase < hi_len);
        phase  = (phase + 1 >= hi_len + lo_len) ? 0 : phase + 1;
        if (rand_en && en_off == 0 && $urandom_range(0, 149) == 0)
            en_off = $urandom_range(1, 8);
        if (en_off > 0) begin
            en = 1'b0;
            en_off--;
        end else begin
            en = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_wave(input int h, input int l);
        hi_len = h;
        lo_len = l;
        phase  = 0;
    endtask

    // Asynchronous reset pulse in the middle of a clock phase
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst_");
        run(3);
        rst_n = 1'b1;
    endtask

    initial begin
        cyc    = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        model_reset();
        en_off = 3;
        run(3);
        rst_n = 1'b1;

        // 10 high / 10 low
        set_wave(10, 10);
        run(200);

        // 3 high / 7 low, then toggle every cycle
        set_wave(3, 7);
        run(100);
        set_wave(1, 1);
        run(40);

        // Stop the input long enough to time out, then restart
        set_wave(5, 5);
        run(30);
        set_wave(0, 1);
        run(1100);
        set_wave(5, 5);
        run(40);

        // Reset mid-period
        set_wave(10, 10);
        run(55);
        pulse_reset();
        run(80);

        // Enable dropped for 5 cycles mid-period
        set_wave(8, 12);
        run(75);
        en_off = 5;
        run(80);

        // Period exactly TIMEOUT, then one cycle longer
        set_wave(400, 600);
        run(3100);
        set_wave(400, 601);
        run(2100);

        // Randomized waveforms with random enable drops
        rand_en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            set_wave($urandom_range(1, 40), $urandom_range(1, 40));
            run($urandom_range(100, 400));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_meter.md
# clk_meter

Measures an externally supplied slow square wave, such as a divided clock, a board oscillator or a sensor pulse train, in units of the system clock. It reports the period and high time of each full cycle of the input. It is the receiving end of the team's clock dividers: a divided clock fed back into this block yields its period, so divider settings can be checked on the board. It sits in the board-level debug path, and its outputs drive the seven-segment display and register readback.

## Interface

Parameters:
- WIDTH, 32: width of the internal counter and of the measurement outputs.
- TIMEOUT, 200_000_000: number of cycles without a rising edge before the input is declared stopped. Must satisfy 2 ≤ TIMEOUT < 2^WIDTH.

Ports:
- clk, input, 1: system clock. Reset is asynchronous and active-low.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: measurement enable, synchronous to clk.
- sig_in, input, 1: signal under measurement. It is asynchronous to clk.
- period, output, WIDTH: clk cycles between the last two detected rising edges.
- high_time, output, WIDTH: clk cycles sig was high within that period.
- valid, output, 1: one-cycle pulse when period and high_time update.
- timeout, output, 1: sticky flag. Set on timeout; cleared by the next valid.

## Operation

**Input conditioning**
- sig_in passes through a 2-FF synchronizer (reset value 0) into sig_s, then a delay register (reset 0) for edge detection.
- rise = sig_s & ~sig_d.
- fall = ~sig_s & sig_d.

**State machine**
- States are IDLE and MEASURE. Reset state is IDLE.
- IDLE:
  - cnt holds 0.
  - rise with en=1: cnt ← 1, then go to MEASURE. This first edge only arms the block; valid is not asserted.
- MEASURE, each cycle with en=1:
  - cnt ← cnt+1.
  - fall: hi_lat ← cnt.
  - rise: period ← cnt, high_time ← hi_lat, valid ← 1, timeout ← 0, cnt ← 1. Stay in MEASURE.
  - cnt == TIMEOUT with no rise: period ← 0, high_time ← 0, timeout ← 1, cnt ← 0, go to IDLE.
  - rise and cnt == TIMEOUT in the same cycle: rise wins.
- en=0 in any state:
  - Next state is IDLE.
  - cnt and hi_lat are cleared.
  - period, high_time and timeout hold their values.
  - valid is 0.
  - The synchronizer keeps running.

**Arithmetic and limits**
- cnt never wraps, because TIMEOUT < 2^WIDTH.
- The minimum measurable period is 2 cycles (sig toggling every cycle gives period=2, high_time=1).
- Input edges faster than clk/2 alias. This is not detected.

**Reset values**
- All outputs are 0.
- cnt, hi_lat and the synchronizer are 0.
- state = IDLE.
- Reset asserted mid-measurement discards the partial period. The first rise after release only arms the block.

## Timing

- A sig_in edge appears as rise or fall on the 3rd clk edge after it is set up (2 synchronizer cycles plus 1 edge-detect cycle). This latency is fixed, so period is exact for a periodic input.
- valid, period and high_time are registered. They update on the clk edge following the cycle in which rise is detected, all in the same cycle.
- valid is high for exactly 1 cycle. It is never asserted on two consecutive cycles.
- timeout rises the cycle after cnt == TIMEOUT was evaluated. It stays high until the next valid and falls in the same cycle that valid rises.

## Structure

- Package clk_meter_pkg holds:
  - the state enum (IDLE, MEASURE);
  - the default WIDTH and TIMEOUT constants, shared with the divider instantiations on the board.
- Sub-module sync_edge contains the 2-FF synchronizer, the delay register and the rise/fall outputs. It is reusable for button inputs.
- The top level holds the FSM, cnt, hi_lat and the output registers.

## Test plan

1. Square wave, 10 cycles high / 10 cycles low, en=1 → no valid on the first rise. After that, valid every 20 cycles with period=20 and high_time=10.
2. 3 high / 7 low → period=10, high_time=3. Then toggle every cycle → period=2, high_time=1.
3. TIMEOUT=1000; sig held low after two rises → exactly 1000 cycles after the last rise is detected, timeout=1 and period=high_time=0. Two further rises → valid with the correct values, and timeout clears in the same cycle.
4. rst_n pulsed low mid-period → all outputs 0 immediately, asynchronously. The first rise after release produces no valid; the second produces a correct measurement.
5. en dropped for 5 cycles mid-period → no valid, outputs held. After en returns, one rise arms the block and the next produces a correct measurement.
6. Rise coinciding with cnt == TIMEOUT (period exactly TIMEOUT) → valid with period=TIMEOUT; timeout stays 0.
